// File: rtl/decode_stage_sb_pkg.sv
// Shared decode definitions: RV32 R/I/S opcode and funct constants, the operation
// enum, the decoded-instruction record and the combinational decode function.
package decode_stage_sb_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_S = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [OP_W-1:0] {
    OP_NONE,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_SB, OP_SH, OP_SW
  } op_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    op_e         op;
    logic [11:0] imm;
    logic        illegal;
  } dec_t;

  // Unused fields stay zero; any unmatched funct combination leaves op at OP_NONE.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];
    d      = '0;
    case (opcode)
      OPC_R: begin
        d.rs1 = instr[19:15];
        d.rs2 = instr[24:20];
        d.rd  = instr[11:7];
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  d.op = OP_ADD;
            F3_SLL:  d.op = OP_SLL;
            F3_SLT:  d.op = OP_SLT;
            F3_SLTU: d.op = OP_SLTU;
            F3_XOR:  d.op = OP_XOR;
            F3_SR:   d.op = OP_SRL;
            F3_OR:   d.op = OP_OR;
            default: d.op = OP_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD)
            d.op = OP_SUB;
          else if (funct3 == F3_SR)
            d.op = OP_SRA;
        end
      end
      OPC_I: begin
        d.rs1 = instr[19:15];
        d.rd  = instr[11:7];
        d.imm = instr[31:20];
        case (funct3)
          F3_ADD:  d.op = OP_ADDI;
          F3_SLT:  d.op = OP_SLTI;
          F3_SLTU: d.op = OP_SLTIU;
          F3_XOR:  d.op = OP_XORI;
          F3_OR:   d.op = OP_ORI;
          F3_AND:  d.op = OP_ANDI;
          F3_SLL:  if (funct7 == F7_BASE) d.op = OP_SLLI;
          default: begin
            if (funct7 == F7_BASE)
              d.op = OP_SRLI;
            else if (funct7 == F7_ALT)
              d.op = OP_SRAI;
          end
        endcase
      end
      OPC_S: begin
        d.rs1 = instr[19:15];
        d.rs2 = instr[24:20];
        d.imm = {instr[31:25], instr[11:7]};
        case (funct3)
          F3_SB:   d.op = OP_SB;
          F3_SH:   d.op = OP_SH;
          F3_SW:   d.op = OP_SW;
          default: d.op = OP_NONE;
        endcase
      end
      default: d = '0;
    endcase
    d.illegal = (d.op == OP_NONE);
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_sb_rd_scoreboard.sv
// Writeback scoreboard: a WB_LATENCY-deep shift register of issued destination
// registers, with two combinational lookup ports for source operands.
module rd_scoreboard #(
  parameter int unsigned WB_LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  logic [4:0] push_rd,
  input  logic [4:0] q1_rd,
  input  logic [4:0] q2_rd,
  output logic       q1_hit,
  output logic       q2_hit
);

  logic [WB_LATENCY-1:0] v_q;
  logic [4:0]            rd_q [WB_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned i = 0; i < WB_LATENCY; i++)
        rd_q[i] <= '0;
    end else begin
      v_q[0]  <= push_valid;
      rd_q[0] <= push_valid ? push_rd : '0;
      for (int unsigned i = 1; i < WB_LATENCY; i++) begin
        v_q[i]  <= v_q[i-1];
        rd_q[i] <= rd_q[i-1];
      end
    end
  end

  always_comb begin
    q1_hit = 1'b0;
    q2_hit = 1'b0;
    for (int unsigned i = 0; i < WB_LATENCY; i++) begin
      if (v_q[i] && (q1_rd != '0) && (rd_q[i] == q1_rd)) q1_hit = 1'b1;
      if (v_q[i] && (q2_rd != '0) && (rd_q[i] == q2_rd)) q2_hit = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage_sb.sv
// RV32 R/I/S decode stage with a one-entry output register, valid/ready on both
// sides, and a writeback scoreboard that stalls decode on RAW hazards.
module decode_stage_sb
  import decode_stage_sb_pkg::*;
#(
  parameter int unsigned OUT_WIDTH   = 5,
  parameter int unsigned WB_LATENCY  = 3,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic [OUT_WIDTH-1:0]   out_operation,
  output logic [11:0]            out_imm,
  output logic                   out_illegal,
  output logic                   stall_decode,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  dec_t                   dec;
  dec_t                   out_q;
  logic                   out_valid_q;
  logic                   issue;
  logic                   accept;
  logic                   hazard;
  logic                   sb_hit1;
  logic                   sb_hit2;
  logic                   push_valid;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  assign dec = decode_instr(in_instr);

  assign issue      = out_valid_q && out_ready && !flush;
  assign push_valid = issue && (out_q.rd != '0) && !out_q.illegal;

  rd_scoreboard #(
    .WB_LATENCY(WB_LATENCY)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .push_valid(push_valid),
    .push_rd   (out_q.rd),
    .q1_rd     (dec.rs1),
    .q2_rd     (dec.rs2),
    .q1_hit    (sb_hit1),
    .q2_hit    (sb_hit2)
  );

  // The held instruction counts as in flight even when it issues this cycle:
  // its rd moves into the scoreboard on the same edge.
  always_comb begin
    hazard = sb_hit1 || sb_hit2;
    if (out_valid_q && !out_q.illegal && (out_q.rd != '0)) begin
      if ((dec.rs1 == out_q.rd) || (dec.rs2 == out_q.rd))
        hazard = 1'b1;
    end
  end

  assign in_ready     = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept       = in_valid && in_ready;
  assign stall_decode = in_valid && hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= dec;
    end else if (issue) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall_decode && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
  end

  assign out_valid     = out_valid_q;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_operation = OUT_WIDTH'(out_q.op);
  assign out_imm       = out_q.imm;
  assign out_illegal   = out_q.illegal;
  assign stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Self-checking bench for decode_stage_sb: vector table, directed hazard/flush/
// saturation sequences, and a randomized run against a per-register busy-time model.
module tb_decode_stage_sb;
  import decode_stage_sb_pkg::*;

  localparam int WB = 3;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal, stall_decode;
  logic [31:0] in_instr;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_operation;
  logic [11:0] out_imm;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_sb #(
    .OUT_WIDTH(5),
    .WB_LATENCY(WB),
    .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_operation(out_operation), .out_imm(out_imm), .out_illegal(out_illegal),
    .stall_decode(stall_decode), .stall_cycles(stall_cycles)
  );

  typedef struct { int rs1, rs2, rd, op, imm, ill; } exp_t;
  typedef struct { logic [31:0] instr; int rs1, rs2, rd, op, imm, ill; } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    step(); step();
    rst = 1'b0;
  endtask

  // Holds in_valid until accepted; reports how many cycles it waited.
  task automatic wait_accept(input int maxc, output int waited);
    int n;
    n = 0;
    #1;
    while (in_ready !== 1'b1) begin
      if (n >= maxc) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=%0d cycles expected<=%0d", n, maxc);
        in_valid = 1'b0;
        waited = n;
        return;
      end
      n++;
      step(); #1;
    end
    waited = n;
    step();
    in_valid = 1'b0;
  endtask

  task automatic present(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
  endtask

  // Reference decode written from the ISA field rules.
  function automatic exp_t ref_dec(input logic [31:0] x);
    exp_t       e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = x[6:0]; f3 = x[14:12]; f7 = x[31:25];
    e = '{default: 0};
    if (opc == 7'h33) begin
      e.rs1 = x[19:15]; e.rs2 = x[24:20]; e.rd = x[11:7];
      if (f7 == 7'h00) begin
        case (f3)
          0: e.op = OP_ADD;  1: e.op = OP_SLL; 2: e.op = OP_SLT; 3: e.op = OP_SLTU;
          4: e.op = OP_XOR;  5: e.op = OP_SRL; 6: e.op = OP_OR;  default: e.op = OP_AND;
        endcase
      end else if (f7 == 7'h20 && f3 == 0) e.op = OP_SUB;
      else if (f7 == 7'h20 && f3 == 5) e.op = OP_SRA;
    end else if (opc == 7'h13) begin
      e.rs1 = x[19:15]; e.rd = x[11:7]; e.imm = x[31:20];
      case (f3)
        0: e.op = OP_ADDI; 2: e.op = OP_SLTI; 3: e.op = OP_SLTIU;
        4: e.op = OP_XORI; 6: e.op = OP_ORI;  7: e.op = OP_ANDI;
        1: e.op = (f7 == 7'h00) ? OP_SLLI : 0;
        default: e.op = (f7 == 7'h00) ? OP_SRLI : (f7 == 7'h20) ? OP_SRAI : 0;
      endcase
    end else if (opc == 7'h23) begin
      e.rs1 = x[19:15]; e.rs2 = x[24:20]; e.imm = {x[31:25], x[11:7]};
      e.op = (f3 == 0) ? OP_SB : (f3 == 1) ? OP_SH : (f3 == 2) ? OP_SW : 0;
    end
    e.ill = (e.op == 0) ? 1 : 0;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] x;
    int k, r;
    x = $urandom;
    k = $urandom_range(0, 9);
    r = $urandom_range(0, 3);
    x[19:15] = 5'($urandom_range(0, 4));
    x[24:20] = 5'($urandom_range(0, 4));
    x[11:7]  = 5'($urandom_range(0, 4));
    if (k < 4)      x[6:0] = 7'h33;
    else if (k < 7) x[6:0] = 7'h13;
    else if (k < 9) x[6:0] = 7'h23;
    if (r < 2)       x[31:25] = 7'h00;
    else if (r == 2) x[31:25] = 7'h20;
    return x;
  endfunction

  vec_t vt [11];
  int   n;
  int   busy_until [32];
  int   cyc;
  logic m_valid;
  exp_t m_dec;
  int   m_stall;
  exp_t d;
  logic exp_hazard, exp_ready;

  initial begin
    vt[0]  = '{32'h00000013, 0,  0,  0, OP_ADDI, 0,     0};
    vt[1]  = '{32'h002081B3, 1,  2,  3, OP_ADD,  0,     0};
    vt[2]  = '{32'h00518213, 3,  0,  4, OP_ADDI, 5,     0};
    vt[3]  = '{32'h00312423, 2,  3,  0, OP_SW,   8,     0};
    vt[4]  = '{32'h0000007F, 0,  0,  0, 0,       0,     1};
    vt[5]  = '{32'h02311093, 2,  0,  1, 0,       12'h023, 1};
    vt[6]  = '{32'h407302B3, 6,  7,  5, OP_SUB,  0,     0};
    vt[7]  = '{32'h4044D413, 9,  0,  8, OP_SRAI, 12'h404, 0};
    vt[8]  = '{32'h023100B3, 2,  3,  1, 0,       0,     1};
    vt[9]  = '{32'hFEA58FA3, 11, 10, 0, OP_SB,   12'hFFF, 0};
    vt[10] = '{32'h0000B023, 1,  0,  0, 0,       0,     1};

    reset_dut();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {out_rs1, out_rs2, out_rd, out_operation, out_imm}, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_stall_cycles", stall_cycles, 0);

    // Vector table: each decoded after a fresh reset, one-cycle latency.
    for (int i = 0; i < 11; i++) begin
      reset_dut();
      out_ready = 1'b1;
      present(vt[i].instr);
      #1;
      chk("vec_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      #1;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_rs1", out_rs1, vt[i].rs1);
      chk("vec_rs2", out_rs2, vt[i].rs2);
      chk("vec_rd", out_rd, vt[i].rd);
      chk("vec_op", out_operation, vt[i].op);
      chk("vec_imm", out_imm, vt[i].imm);
      chk("vec_illegal", out_illegal, vt[i].ill);
      chk("vec_no_stall", stall_cycles, 0);
    end

    // RAW on rs1: ADD x3 then ADDI x4,x3,5.
    reset_dut();
    out_ready = 1'b1;
    present(32'h002081B3); wait_accept(5, n);
    present(32'h00518213);
    #1; chk("raw_stall_seen", stall_decode, 1);
    wait_accept(20, n);
    chk("raw_stall_len", n, 4);
    chk("raw_imm", out_imm, 5);
    chk("raw_rd", out_rd, 4);
    chk("raw_stall_cycles", stall_cycles, 4);

    // RAW on rs2: ADD x3 then SW x3,8(x2).
    reset_dut();
    out_ready = 1'b1;
    present(32'h002081B3); wait_accept(5, n);
    present(32'h00312423); wait_accept(20, n);
    chk("sw_stall_len", n, 4);
    chk("sw_rs1", out_rs1, 2);
    chk("sw_rs2", out_rs2, 3);
    chk("sw_rd", out_rd, 0);
    chk("sw_imm", out_imm, 8);
    chk("sw_op", out_operation, OP_SW);

    // Output backpressure: held ADD stays put, issues exactly once.
    reset_dut();
    present(32'h002081B3); wait_accept(5, n);
    present(32'h00108293);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_rd", out_rd, 3);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_no_stall", stall_decode, 0);
      step();
    end
    out_ready = 1'b1;
    #1; chk("hold_release_ready", in_ready, 1);
    step();
    present(32'h00518213); wait_accept(20, n);
    chk("hold_single_push", n, WB);

    // Flush discards the held ADD x3; it never reaches the scoreboard.
    reset_dut();
    present(32'h002081B3); wait_accept(5, n);
    flush = 1'b1;
    present(32'h00518213);
    #1; chk("flush_blocks_accept", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_no_stall", stall_decode, 0);
    step();
    in_valid = 1'b0;
    #1;
    chk("flush_next_valid", out_valid, 1);
    chk("flush_next_rd", out_rd, 4);

    // Illegal instruction with rd=1 creates no hazard.
    reset_dut();
    out_ready = 1'b1;
    present(32'h023100B3); wait_accept(5, n);
    present(32'h00008113); wait_accept(20, n);
    chk("illegal_no_push", n, 0);
    chk("illegal_next_rd", out_rd, 2);

    // Saturation of the stall counter under a held hazard.
    reset_dut();
    present(32'h002081B3); wait_accept(5, n);
    present(32'h00518213);
    repeat (100) step();
    chk("sat_partial", stall_cycles, 100);
    repeat (69900) step();
    chk("sat_value", stall_cycles, 16'hFFFF);
    chk("sat_still_stall", stall_decode, 1);
    rst = 1'b1; step(); rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_stall_cycles", stall_cycles, 0);
    chk("midrst_out_valid", out_valid, 0);

    // Randomized run against busy-until model.
    reset_dut();
    foreach (busy_until[i]) busy_until[i] = -1;
    m_valid = 1'b0; m_stall = 0; cyc = 0; m_dec = '{default: 0};
    for (int t = 0; t < 3000; t++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = gen_instr();
      #3;
      d = ref_dec(in_instr);
      exp_hazard = 1'b0;
      if (d.rs1 != 0 && (busy_until[d.rs1] >= cyc || (m_valid && !m_dec.ill && m_dec.rd == d.rs1)))
        exp_hazard = 1'b1;
      if (d.rs2 != 0 && (busy_until[d.rs2] >= cyc || (m_valid && !m_dec.ill && m_dec.rd == d.rs2)))
        exp_hazard = 1'b1;
      exp_ready = (!m_valid || out_ready) && !exp_hazard && !flush;
      if (!rst) begin
        chk("rnd_in_ready", in_ready, exp_ready);
        chk("rnd_stall", stall_decode, in_valid && exp_hazard);
        chk("rnd_out_valid", out_valid, m_valid);
        chk("rnd_stall_cycles", stall_cycles, m_stall);
        if (m_valid) begin
          chk("rnd_rs1", out_rs1, m_dec.rs1);
          chk("rnd_rs2", out_rs2, m_dec.rs2);
          chk("rnd_rd", out_rd, m_dec.rd);
          chk("rnd_op", out_operation, m_dec.op);
          chk("rnd_imm", out_imm, m_dec.imm);
          chk("rnd_illegal", out_illegal, m_dec.ill);
        end
      end
      if (rst) begin
        foreach (busy_until[i]) busy_until[i] = -1;
        m_valid = 1'b0; m_stall = 0;
      end else begin
        if (in_valid && exp_hazard && m_stall != 65535) m_stall++;
        if (m_valid && out_ready && !flush && m_dec.rd != 0 && !m_dec.ill)
          busy_until[m_dec.rd] = cyc + WB;
        if (flush) m_valid = 1'b0;
        else if (in_valid && exp_ready) begin
          m_valid = 1'b1;
          m_dec   = d;
        end else if (m_valid && out_ready) m_valid = 1'b0;
      end
      cyc++;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_sb.md
Name: decode_stage_sb

Overview:
Parametrised successor to the single-instruction decode block. Decodes RV32 R/I/S-type instructions into register indices, an immediate and an operation code, and holds the result in a one-entry output register with valid/ready handshakes on both sides. An internal writeback scoreboard tracks destination registers of issued instructions and stalls decode on RAW hazards. Sits between the fetch buffer and the ALU issue stage.

Parameters:
OUT_WIDTH, 5, width of the operation code (package op encoding must fit).
WB_LATENCY, 3, cycles from issue handshake until the issued rd is architecturally readable; range 1..8.
STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  kill the instruction held in the output register
in_valid  input  1  fetch presents in_instr
in_ready  output  1  decode accepts in_instr this cycle
in_instr  input  32  raw instruction
out_valid  output  1  output register holds a decoded instruction
out_ready  input  1  issue stage consumes this cycle
out_rs1  output  5  source register 1 (0 when unused)
out_rs2  output  5  source register 2 (0 when unused)
out_rd  output  5  destination (0 for S-type)
out_operation  output  OUT_WIDTH  op code from package, 0 when illegal
out_imm  output  12  I-imm {31:20} or S-imm {31:25,11:7}; 0 for R-type
out_illegal  output  1  unsupported opcode/funct combination
stall_decode  output  1  in_valid high and hazard blocks acceptance
stall_cycles  output  STALL_CNT_W  saturating count of stall_decode cycles

Behaviour:
- Reset (rst high at posedge): out_valid=0, all out_* fields=0, out_illegal=0, scoreboard cleared, stall_cycles=0. Reset mid-operation discards held and in-flight instructions.
- Decode is combinational on in_instr; results captured into output register on accept (in_valid && in_ready). Latency: 1 cycle accept-to-out_valid.
- Accepted with no out_ready stall: out_valid stays high, all out_* fields stable until out_valid && out_ready.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Scoreboard: shift register of WB_LATENCY entries {v, rd}. On issue (out_valid && out_ready && !flush) with out_rd!=0 and not illegal, push {1,out_rd} at head; otherwise push {0,0}. Shifts every cycle; tail entry retired.
- Hazard: any used source (rs1 for R/I/S; rs2 for R/S) of in_instr, nonzero, equal to out_rd of a valid, non-illegal output register or to any valid scoreboard entry. x0 never hazards. No forwarding.
- stall_decode = in_valid && hazard. stall_cycles increments each stall_decode cycle, saturates at all-ones.
- flush: clears out_valid next edge; held instruction not pushed to scoreboard; scoreboard entries unaffected (older instructions still write back). Accept and issue both blocked in a flush cycle.
- Illegal: opcode not R/I/S, or funct combination absent from package table (incl. SLLI/SRLI with imm[11:5]!=0, SRAI with imm[11:5]!=0100000) -> out_illegal=1, operation=0, fields decoded by opcode format (all zero for unknown opcode), passes handshake normally.
- Simultaneous issue and accept: allowed same cycle; new instruction's hazard check still sees the outgoing rd (in output register this cycle, scoreboard next cycle).

Decomposition:
- Shared package: opcode constants (R/I/S), funct3/funct7 constants, op-code enum typedef (width OUT_WIDTH), a decoded-instruction struct {rs1, rs2, rd, op, imm, illegal}, and a decode function returning it.
- Sub-module: rd_scoreboard (shift register plus two-port match lookup, WB_LATENCY parameter); decode_stage_sb instantiates it.

Test Plan:
- Reset then in_valid with ADDI x0,x0,0 (0x00000013), out_ready=1 -> out_valid at cycle 1, op=ADDI, rd=0, imm=0, no stall ever.
- ADD x3,x1,x2 (0x002081B3) accepted cycle 0, issued cycle 1; ADDI x4,x3,5 (0x00518213) presented from cycle 1 -> stall_decode cycles 1-4, accepted cycle 5, out_imm=5, stall_cycles=4 (WB_LATENCY=3).
- ADD x3 then SW x3,8(x2) (0x00312423) -> stall on rs2 match; after release out_rs1=2, out_rs2=3, out_rd=0, out_imm=8, op=SW.
- out_ready held 0 for 5 cycles with ADD held -> out fields stable, in_ready=0, scoreboard empty; at out_ready=1 issue occurs once, one entry pushed.
- flush while ADD x3 held -> out_valid=0 next cycle, following ADDI x4,x3,5 accepted with no stall.
- Opcode 0x7F and SLLI with imm[11:5]=0000001 -> out_illegal=1, operation=0, no scoreboard push; stall_cycles saturates at 0xFFFF under a forced 70000-cycle stall.
